// File: rtl/vga_timing_if.sv
// Update handshake between game logic and the VGA timing block.
// Game logic posts a grid/state pair and holds it until the acknowledge comes back.
interface vga_timing_if;
    logic [3:0] grid_in [0:15];
    logic [1:0] state_in;
    logic       upd_req;
    logic       upd_ack;

    modport master (
        output grid_in,
        output state_in,
        output upd_req,
        input  upd_ack
    );

    modport slave (
        input  grid_in,
        input  state_in,
        input  upd_req,
        output upd_ack
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing, with a delayed sync/enable and a vblank-synchronised grid/state double buffer.
// Build option VGA_FRAME_CNT_EN adds the completed-frame counter; without it, frame_cnt is tied to 0.
module vga_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic          vgaclk,
    input  logic          rst,
    vga_timing_if.slave   upd,
    output logic [3:0]    grid_out [0:15],
    output logic [1:0]    state_out,
    output logic [9:0]    hc,
    output logic [9:0]    vc,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          vblank,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] VB_PREV  = 10'(V_VISIBLE - 1);

    logic       hc_wrap;
    logic       vblank_next;
    logic [2:0] sync_raw;

    assign hc_wrap     = (hc == H_LAST);
    assign vblank_next = hc_wrap && (vc == VB_PREV);

    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc_wrap) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    always_comb begin
        sync_raw    = 3'b110;
        sync_raw[2] = !((hc >= HS_START) && (hc < HS_END));
        sync_raw[1] = !((vc >= VS_START) && (vc < VS_END));
        sync_raw[0] = (hc < H_VIS) && (vc < V_VIS);
    end

    // Sync and enable are delayed to line up with the renderer's registered pixel output.
    generate
        if (SYNC_DELAY == 0) begin : g_nodelay
            assign {hsync, vsync, de} = sync_raw;
        end else begin : g_delay
            logic [2:0] pipe [SYNC_DELAY];

            always_ff @(posedge vgaclk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        pipe[i] <= 3'b110;
                    end
                end else begin
                    pipe[0] <= sync_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign {hsync, vsync, de} = pipe[SYNC_DELAY-1];
        end
    endgenerate

    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            vblank <= 1'b0;
        end else begin
            vblank <= vblank_next;
        end
    end

    // The whole board is swapped on one edge at the start of blanking so no frame shows a partial update.
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                grid_out[i] <= 4'h0;
            end
            state_out   <= 2'b00;
            upd.upd_ack <= 1'b0;
        end else begin
            upd.upd_ack <= vblank && upd.upd_req;
            if (vblank && upd.upd_req) begin
                for (int i = 0; i < 16; i++) begin
                    grid_out[i] <= upd.grid_in[i];
                end
                state_out <= upd.state_in;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= 8'd0;
        end else if (vblank) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing using a shrunken raster so many whole frames fit in a short run.
// Expected values come from arithmetic on the cycle count since reset plus a model of the posted board.
module tb_vga_timing;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VV = 5;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int SD = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int VBCYC = VV * HT;

    logic       vgaclk;
    logic       rst;
    logic [3:0] grid_out [0:15];
    logic [1:0] state_out;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       vblank;
    logic [7:0] frame_cnt;

    vga_timing_if bus ();

    vga_timing #(
        .H_VISIBLE (HV),
        .H_FRONT   (HF),
        .H_SYNC    (HS),
        .H_BACK    (HB),
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB),
        .SYNC_DELAY(SD)
    ) dut (
        .vgaclk   (vgaclk),
        .rst      (rst),
        .upd      (bus),
        .grid_out (grid_out),
        .state_out(state_out),
        .hc       (hc),
        .vc       (vc),
        .hsync    (hsync),
        .vsync    (vsync),
        .de       (de),
        .vblank   (vblank),
        .frame_cnt(frame_cnt)
    );

    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         t = 0;
    logic [3:0] exp_grid [0:15];
    logic [1:0] exp_state;
    logic       exp_ack;

    function automatic logic [9:0] m_hc(int tt);
        return 10'(tt % HT);
    endfunction

    function automatic logic [9:0] m_vc(int tt);
        return 10'((tt / HT) % VT);
    endfunction

    function automatic logic m_vblank(int tt);
        return (tt % FR) == VBCYC;
    endfunction

    // {hsync, vsync, de} as seen on the outputs, i.e. the raster rule applied SD cycles earlier.
    function automatic logic [2:0] m_sync(int tt);
        int h;
        int v;
        if (tt < SD) return 3'b110;
        h = (tt - SD) % HT;
        v = ((tt - SD) / HT) % VT;
        return {!(h >= HV + HF && h < HV + HF + HS),
                !(v >= VV + VF && v < VV + VF + VS),
                (h < HV) && (v < VV)};
    endfunction

    function automatic logic [7:0] m_frame(int tt);
`ifdef VGA_FRAME_CNT_EN
        if (tt <= VBCYC) return 8'd0;
        return 8'(((tt - VBCYC - 1) / FR + 1) % 256);
`else
        return 8'(tt * 0);
`endif
    endfunction

    function automatic logic [63:0] pack(input logic [3:0] g [0:15]);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[i*4 +: 4] = g[i];
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, expv, t);
        end
    endtask

    task automatic checkAll();
        logic [2:0] s;
        s = m_sync(t);
        checkOutput("hc", 64'(hc), 64'(m_hc(t)));
        checkOutput("vc", 64'(vc), 64'(m_vc(t)));
        checkOutput("hsync", 64'(hsync), 64'(s[2]));
        checkOutput("vsync", 64'(vsync), 64'(s[1]));
        checkOutput("de", 64'(de), 64'(s[0]));
        checkOutput("vblank", 64'(vblank), 64'(m_vblank(t)));
        checkOutput("upd_ack", 64'(bus.upd_ack), 64'(exp_ack));
        checkOutput("grid_out", pack(grid_out), pack(exp_grid));
        checkOutput("state_out", 64'(state_out), 64'(exp_state));
        checkOutput("frame_cnt", 64'(frame_cnt), 64'(m_frame(t)));
    endtask

    task automatic modelReset();
        t = 0;
        for (int i = 0; i < 16; i++) exp_grid[i] = 4'h0;
        exp_state = 2'b00;
        exp_ack   = 1'b0;
    endtask

    // One pixel clock: the model samples the same inputs the DUT sees at the edge.
    task automatic applyStimulus();
        @(posedge vgaclk);
        if (m_vblank(t) && bus.upd_req) begin
            for (int i = 0; i < 16; i++) exp_grid[i] = bus.grid_in[i];
            exp_state = bus.state_in;
            exp_ack   = 1'b1;
        end else begin
            exp_ack = 1'b0;
        end
        t++;
        @(negedge vgaclk);
        checkAll();
    endtask

    task automatic randomGrid();
        for (int i = 0; i < 16; i++) bus.grid_in[i] = 4'($urandom);
        bus.state_in = 2'($urandom);
    endtask

    initial begin
        logic seen;

        rst          = 1'b0;
        bus.upd_req  = 1'b0;
        bus.state_in = 2'b00;
        for (int i = 0; i < 16; i++) bus.grid_in[i] = 4'h0;
        modelReset();
        repeat (3) @(negedge vgaclk);
        $display("[TB] reset state");
        checkAll();
        rst = 1'b1;

        $display("[TB] idle frames with wandering grid_in");
        for (int c = 0; c < 2 * FR + 37; c++) begin
            bus.grid_in[$urandom_range(0, 15)] = 4'($urandom);
            applyStimulus();
        end

        $display("[TB] mid-frame post of grid[5]=3 state=01");
        randomGrid();
        bus.grid_in[5] = 4'h3;
        bus.state_in   = 2'b01;
        bus.upd_req    = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 2 * FR && !seen; c++) begin
            applyStimulus();
            if (bus.upd_ack) seen = 1'b1;
        end
        checkOutput("ack_seen", 64'(seen), 64'd1);
        checkOutput("ack_hc", 64'(hc), 64'd1);
        checkOutput("ack_vc", 64'(vc), 64'(VV));
        checkOutput("grid5", 64'(grid_out[5]), 64'h3);
        checkOutput("state01", 64'(state_out), 64'h1);
        bus.upd_req = 1'b0;

        $display("[TB] grid_in change with no request");
        bus.grid_in[0] = 4'h1;
        for (int c = 0; c < FR / 2; c++) applyStimulus();
        bus.grid_in[0] = 4'h2;
        for (int c = 0; c < FR; c++) applyStimulus();

        $display("[TB] request first raised on the vblank cycle");
        seen = 1'b0;
        for (int c = 0; c < 2 * FR && !seen; c++) begin
            applyStimulus();
            if (m_vblank(t)) seen = 1'b1;
        end
        checkOutput("vblank_found", 64'(seen), 64'd1);
        randomGrid();
        bus.upd_req = 1'b1;
        applyStimulus();
        checkOutput("late_req_ack", 64'(bus.upd_ack), 64'd1);
        bus.upd_req = 1'b0;
        for (int c = 0; c < 20; c++) applyStimulus();

        $display("[TB] reset mid-frame with a request pending");
        randomGrid();
        bus.upd_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 2 * FR && !seen; c++) begin
            applyStimulus();
            if (m_vc(t) == 10'd3 && m_hc(t) == 10'd4) seen = 1'b1;
        end
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_hc", 64'(hc), 64'd0);
        checkOutput("rst_vc", 64'(vc), 64'd0);
        checkOutput("rst_grid", pack(grid_out), 64'd0);
        checkOutput("rst_state", 64'(state_out), 64'd0);
        checkOutput("rst_ack", 64'(bus.upd_ack), 64'd0);
        checkOutput("rst_hsync", 64'(hsync), 64'd1);
        checkOutput("rst_vsync", 64'(vsync), 64'd1);
        checkOutput("rst_de", 64'(de), 64'd0);
        checkOutput("rst_frame", 64'(frame_cnt), 64'd0);
        @(negedge vgaclk);
        @(negedge vgaclk);
        bus.upd_req = 1'b0;
        rst = 1'b1;
        modelReset();
        checkAll();

        $display("[TB] random requester over 262 frames");
        for (int c = 0; c < 262 * FR; c++) begin
            if (bus.upd_req) begin
                if (bus.upd_ack && $urandom_range(0, 3) != 0) bus.upd_req = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                randomGrid();
                bus.upd_req = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.grid_in[$urandom_range(0, 15)] = 4'($urandom);
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock.
- Drives hc/vc to the pixel renderer and hsync/vsync to the connector.
- Delays sync and display-enable so they line up with the renderer's registered RGB output.
- Double-buffers the 4x4 game grid and game state: game logic posts an update, and the block swaps it in only at the start of vertical blanking, so no frame ever shows a half-updated board.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline stages on hsync/vsync/de (0..3)

Ports:
- vgaclk  in  1  25 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- grid_in  in  4 x16 (unpacked [0:15])  pending grid from game logic
- state_in  in  2  pending game state
- upd_req  in  1  level request to publish grid_in/state_in
- upd_ack  out  1  one-cycle acknowledge of capture
- grid_out  out  4 x16 (unpacked [0:15])  frame-stable grid to renderer
- state_out  out  2  frame-stable state to renderer
- hc  out  10  horizontal pixel counter, undelayed
- vc  out  10  vertical line counter, undelayed
- hsync  out  1  active-low horizontal sync, delayed SYNC_DELAY
- vsync  out  1  active-low vertical sync, delayed SYNC_DELAY
- de  out  1  display enable, delayed SYNC_DELAY
- vblank  out  1  one-cycle pulse at start of vertical blanking
- frame_cnt  out  8  completed-frame counter

Behaviour:
- Derived constants:
  - H_TOTAL = sum of all H_* parameters (800 at defaults).
  - V_TOTAL = sum of all V_* parameters (525 at defaults).
- Reset (async assert, sync release): hc=0, vc=0, hsync=1, vsync=1, de=0, vblank=0, upd_ack=0, frame_cnt=0, all grid_out entries=0, state_out=0. Delay pipeline stages are loaded with the inactive values (1,1,0).
- hc counts 0..H_TOTAL-1 and wraps to 0.
- vc increments on the cycle hc wraps. vc wraps from V_TOTAL-1 to 0 on the same cycle hc wraps.
- Raw (undelayed) signals:
  - hsync_raw = 0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync_raw = 0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - de_raw = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- hsync/vsync/de equal the raw values delayed exactly SYNC_DELAY clocks. SYNC_DELAY=0 makes them combinational from registered counters.
- hc/vc are never delayed; the renderer registers its own output.
- vblank is registered and high for exactly one cycle, the cycle in which hc==0 && vc==V_VISIBLE.
- Update handshake:
  - Game logic raises upd_req and holds grid_in/state_in stable until it sees upd_ack.
  - On a vblank cycle with upd_req=1: grid_out<=grid_in and state_out<=state_in (all 16 entries in the same edge), then upd_ack=1 on the following cycle only.
  - upd_req first sampled high on the vblank cycle itself is captured in that frame.
  - upd_req low at vblank: grid_out/state_out hold and no ack is issued.
  - Requester must drop upd_req within the frame after the ack; if it is still high at the next vblank, a second capture and ack occur (legal, idempotent).
  - Changes to grid_in between vblanks never reach grid_out.
- frame_cnt increments on each vblank cycle and wraps 255->0.
- Reset asserted mid-frame or mid-handshake: all state returns to reset values immediately. Any pending request is dropped; the requester re-issues it because no ack was seen.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
  - Defined: frame_cnt behaves as above.
  - Undefined: no counter register is built and frame_cnt is tied to 0. All other behaviour is unchanged.

Test Plan:
- Release reset, run 420000 clocks -> hc wraps at 799; vc wraps at 524 exactly 800*525 clocks after release; hsync low for 96 clocks starting when raw hc=656; vsync low for 1600 clocks (lines 490-491).
- SYNC_DELAY=1: check de against hc/vc -> de rises 1 clock after (hc=0, vc=0) and falls 1 clock after hc=640; de is 0 throughout lines 480-524.
- upd_req=1 with grid_in[5]=4'h3, state_in=2'b01 mid-frame -> grid_out unchanged until the (hc=0, vc=480) cycle, updates on that edge; upd_ack high one cycle at hc=1.
- Change grid_in[0] from 4'h1 to 4'h2 while upd_req=0 across a vblank -> grid_out[0] unchanged, no upd_ack.
- Assert rst at vc=300 with upd_req high -> hc=vc=0, grid_out=0, upd_ack=0, hsync=vsync=1; restart timing matches a cold start.
- VGA_FRAME_CNT_EN defined, run 256 frames -> frame_cnt wraps 255->0; undefined -> frame_cnt stays 0.
